moldudp64_tx: RTL

// Transmit side of the MoldUDP64 path. Builds one MoldUDP64 packet from a packet request and a stream of

---
 rtl/moldudp64_tx.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/moldudp64_tx.sv
// MoldUDP64 transmit framer: header + length-prefixed messages packed into a 64-bit AXI stream.
// A byte carry register (0..7 pending bytes) realigns each field into full beats.
//
// state | meaning
// IDLE  | waiting for a packet request; sequence counter may be loaded
// H0    | emit session id bytes 0..7
// H1    | emit session id bytes 8..9 and header seq bytes 0..5
// H2    | park header seq bytes 6..7 and message count in carry (or close a heartbeat)
// LEN   | wait for a start beat, append its 2-byte length
// DATA  | append message payload bytes
// FLUSH | emit the final partial beat from carry
module moldudp64_tx #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = 8,
    parameter int ML_W       = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [79:0]           cfg_sid_i,
    input  logic                  seq_init_v_i,
    input  logic [63:0]           seq_init_i,
    input  logic                  pkt_v_i,
    input  logic [ML_W-1:0]       pkt_msg_cnt_i,
    output logic                  pkt_ready_o,
    input  logic                  mold_msg_v_i,
    input  logic                  mold_msg_start_i,
    input  logic [ML_W-1:0]       mold_msg_len_i,
    input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
    output logic                  mold_msg_ready_o,
    output logic                  upd_axis_tvalid_o,
    output logic [AXI_KEEP_W-1:0] upd_axis_tkeep_o,
    output logic [AXI_DATA_W-1:0] upd_axis_tdata_o,
    output logic                  upd_axis_tlast_o,
    output logic                  upd_axis_tuser_o,
    input  logic                  upd_axis_tready_i,
    output logic [63:0]           seq_num_o
);

    typedef enum logic [2:0] {IDLE, H0, H1, H2, LEN, DATA, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [63:0]             seq_q, seq_d;
    logic [63:0]             seq_hdr_q, seq_hdr_d;
    logic [ML_W-1:0]         cnt_q, cnt_d;
    logic [ML_W-1:0]         left_q, left_d;
    logic [ML_W-1:0]         rem_q, rem_d;
    logic [AXI_DATA_W-1:0]   carry_q, carry_d;
    logic [2:0]              clen_q, clen_d;
    logic                    tvalid_q, tvalid_d;
    logic [AXI_KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic [AXI_DATA_W-1:0]   tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;

    logic                    adv;
    logic [3:0]              take_n;
    logic [AXI_DATA_W-1:0]   in_bytes;
    logic [3:0]              in_n;
    logic                    step;
    logic                    msg_end;
    logic                    emit;
    logic [AXI_DATA_W-1:0]   emit_data;
    logic [AXI_KEEP_W-1:0]   emit_keep;
    logic                    emit_last;
    logic [2*AXI_DATA_W-1:0] cat;
    logic [3:0]              tot;

    function automatic logic [63:0] bswap64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = x[63-8*i -: 8];
        return r;
    endfunction

    function automatic logic [7:0] thermo8(input logic [3:0] n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (4'(i) < n);
        return r;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [3:0] n);
        logic [7:0]  t;
        logic [63:0] r;
        t = thermo8(n);
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{t[i]}};
        return r;
    endfunction

    assign adv    = ~tvalid_q | upd_axis_tready_i;
    assign take_n = (rem_q >= ML_W'(8)) ? 4'd8 : 4'(rem_q);

    always_comb begin
        state_d          = state_q;
        seq_d            = seq_q;
        seq_hdr_d        = seq_hdr_q;
        cnt_d            = cnt_q;
        left_d           = left_q;
        rem_d            = rem_q;
        carry_d          = carry_q;
        clen_d           = clen_q;
        tvalid_d         = tvalid_q;
        tkeep_d          = tkeep_q;
        tdata_d          = tdata_q;
        tlast_d          = tlast_q;
        pkt_ready_o      = 1'b0;
        mold_msg_ready_o = 1'b0;
        in_bytes         = '0;
        in_n             = 4'd0;
        step             = 1'b0;
        msg_end          = 1'b0;
        emit             = 1'b0;
        emit_data        = '0;
        emit_keep        = 8'hFF;
        emit_last        = 1'b0;
        cat              = '0;
        tot              = 4'd0;

        case (state_q)
            IDLE: begin
                pkt_ready_o = ~seq_init_v_i;
                if (seq_init_v_i) begin
                    seq_d = seq_init_i;
                end else if (pkt_v_i) begin
                    cnt_d     = pkt_msg_cnt_i;
                    left_d    = pkt_msg_cnt_i;
                    seq_hdr_d = seq_q;
                    seq_d     = seq_q + {{(64-ML_W){1'b0}}, pkt_msg_cnt_i};
                    state_d   = H0;
                end
            end
            H0: if (adv) begin
                emit      = 1'b1;
                emit_data = bswap64(cfg_sid_i[79:16]);
                state_d   = H1;
            end
            H1: if (adv) begin
                emit      = 1'b1;
                emit_data = bswap64({cfg_sid_i[15:0], seq_hdr_q[63:16]});
                state_d   = H2;
            end
            H2: if (adv) begin
                if (cnt_q == '0) begin
                    emit      = 1'b1;
                    emit_data = {32'b0, cnt_q[7:0], cnt_q[15:8], seq_hdr_q[7:0], seq_hdr_q[15:8]};
                    emit_keep = 8'h0F;
                    emit_last = 1'b1;
                    state_d   = IDLE;
                end else begin
                    carry_d = {32'b0, cnt_q[7:0], cnt_q[15:8], seq_hdr_q[7:0], seq_hdr_q[15:8]};
                    clen_d  = 3'd4;
                    state_d = LEN;
                end
            end
            LEN: if (adv && mold_msg_v_i && mold_msg_start_i) begin
                in_bytes = {48'b0, mold_msg_len_i[7:0], mold_msg_len_i[15:8]};
                in_n     = 4'd2;
                step     = 1'b1;
                rem_d    = mold_msg_len_i;
                // A zero-length message has no payload beat, so its start beat is retired here.
                if (mold_msg_len_i == '0) begin
                    mold_msg_ready_o = 1'b1;
                    msg_end          = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                mold_msg_ready_o = adv;
                if (adv && mold_msg_v_i) begin
                    in_bytes = mold_msg_data_i;
                    in_n     = take_n;
                    step     = 1'b1;
                    rem_d    = rem_q - ML_W'(take_n);
                    msg_end  = (rem_q <= ML_W'(8));
                end
            end
            FLUSH: if (adv) begin
                emit      = 1'b1;
                emit_data = carry_q;
                emit_keep = thermo8({1'b0, clen_q});
                emit_last = 1'b1;
                carry_d   = '0;
                clen_d    = 3'd0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (step) begin
            cat = {64'b0, carry_q} | ({64'b0, in_bytes & byte_mask(in_n)} << {clen_q, 3'b000});
            tot = {1'b0, clen_q} + in_n;
            clen_d = tot[2:0];
            if (tot[3]) begin
                emit      = 1'b1;
                emit_data = cat[63:0];
                carry_d   = cat[127:64];
            end else begin
                carry_d = cat[63:0];
            end
        end

        if (msg_end) begin
            left_d = left_q - ML_W'(1);
            if (left_q != ML_W'(1)) begin
                state_d = LEN;
            end else if (emit && clen_d == 3'd0) begin
                emit_last = 1'b1;
                state_d   = IDLE;
            end else begin
                state_d = FLUSH;
            end
        end

        if (adv) begin
            tvalid_d = emit;
            tkeep_d  = emit ? emit_keep : '0;
            tlast_d  = emit & emit_last;
            if (emit) tdata_d = emit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            seq_q     <= 64'd1;
            seq_hdr_q <= '0;
            cnt_q     <= '0;
            left_q    <= '0;
            rem_q     <= '0;
            carry_q   <= '0;
            clen_q    <= 3'd0;
            tvalid_q  <= 1'b0;
            tkeep_q   <= '0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            seq_hdr_q <= seq_hdr_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            rem_q     <= rem_d;
            carry_q   <= carry_d;
            clen_q    <= clen_d;
            tvalid_q  <= tvalid_d;
            tkeep_q   <= tkeep_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
        end
    end

    assign upd_axis_tvalid_o = tvalid_q;
    assign upd_axis_tkeep_o  = tkeep_q;
    assign upd_axis_tdata_o  = tdata_q;
    assign upd_axis_tlast_o  = tlast_q;
    assign upd_axis_tuser_o  = 1'b0;
    assign seq_num_o         = seq_q;

endmodule
